fft_stage_sequencer: RTL and testbench



---
 rtl/fft_pkg.sv | 28 ++
 rtl/fft_stage_sequencer.sv | 135 +++++++++++++
 tb/tb_fft_stage_sequencer.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared constants for the 32-point radix-2 FFT datapath and the stage sequencer
// state encoding.
package fft_pkg;

    localparam int NUMSTAGES  = 5;
    localparam int NUMSAMPLES = 1 << NUMSTAGES;
    localparam int WORDSIZE   = 16;
    localparam int WL         = WORDSIZE;
    localparam int IWL        = 4;
    localparam int FWL        = WL - IWL;

    // Butterfly index width per stage: NUMSAMPLES/2 butterflies over a 2-wide datapath.
    function automatic int cnt_width(input int num_stages);
        return num_stages - 2;
    endfunction

    localparam int CNT_W   = cnt_width(NUMSTAGES);
    localparam int STAGE_W = 3;
    localparam int DRAIN_W = 4;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_RUN   = 2'd1,
        SEQ_DRAIN = 2'd2,
        SEQ_DONE  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/fft_stage_sequencer.sv
// Walks every FFT stage after one start pulse, producing the counter_r/stage_num_r
// sequence for mux_control with a pipeline-drain gap between stages.
module fft_stage_sequencer #(
    parameter int NUMSTAGES = fft_pkg::NUMSTAGES,
    parameter int CNT_W     = fft_pkg::cnt_width(NUMSTAGES),
    parameter int PIPE_LAT  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stall,
    output logic [CNT_W-1:0] counter_r,
    output logic [2:0]       stage_num_r,
    output logic             run_en,
    output logic             bank_sel,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state_dbg
);
    import fft_pkg::*;

    localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [2:0]         LAST_STAGE = 3'(NUMSTAGES - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);

    // Handshake: start is a level sampled only while IDLE; stall freezes RUN/DRAIN
    // for every cycle it is high. Neither is acknowledged.
    seq_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         stage_q, stage_d;
    logic               bank_q, bank_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic               start_q, start_d;
    logic               stall_q, stall_d;
    logic               advance;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEQ_IDLE;
            cnt_q   <= '0;
            stage_q <= '0;
            bank_q  <= 1'b0;
            drain_q <= '0;
            start_q <= 1'b0;
            stall_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
            bank_q  <= bank_d;
            drain_q <= drain_d;
            start_q <= start_d;
            stall_q <= stall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;
        bank_d  = bank_q;
        drain_d = drain_q;
        start_d = 1'b0;
        stall_d = stall && ((state_q == SEQ_RUN) || (state_q == SEQ_DRAIN));
        advance = 1'b0;

        case (state_q)
            SEQ_IDLE: begin
                if (start_q) begin
                    state_d = SEQ_RUN;
                    cnt_d   = '0;
                    stage_d = '0;
                    bank_d  = 1'b0;
                end else begin
                    start_d = start;
                end
            end
            SEQ_RUN: begin
                if (!stall) begin
                    if (cnt_q == CNT_MAX) begin
                        if (PIPE_LAT > 0) begin
                            state_d = SEQ_DRAIN;
                            drain_d = '0;
                        end else begin
                            advance = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            SEQ_DRAIN: begin
                if (!stall) begin
                    if (drain_q == DRAIN_LAST) begin
                        advance = 1'b1;
                    end else begin
                        drain_d = drain_q + DRAIN_W'(1);
                    end
                end
            end
            SEQ_DONE: begin
                state_d = SEQ_IDLE;
            end
            default: begin
                state_d = SEQ_IDLE;
            end
        endcase

        // The counter wraps only here, never by free-running past CNT_MAX.
        if (advance) begin
            drain_d = '0;
            cnt_d   = '0;
            if (stage_q < LAST_STAGE) begin
                state_d = SEQ_RUN;
                stage_d = stage_q + 3'd1;
                bank_d  = ~bank_q;
            end else begin
                state_d = SEQ_DONE;
                stage_d = '0;
                bank_d  = 1'b0;
            end
        end
    end

    always_comb begin
        run_en      = (state_q == SEQ_RUN) && !stall_q;
        busy        = (state_q == SEQ_RUN) || (state_q == SEQ_DRAIN);
        done        = (state_q == SEQ_DONE);
        counter_r   = cnt_q;
        stage_num_r = stage_q;
        bank_sel    = bank_q;
        state_dbg   = state_q;
    end

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed bench for fft_stage_sequencer: default build plus a PIPE_LAT=0 build,
// checked against hand-computed cycle tables.
module tb_fft_stage_sequencer;

    typedef struct {
        int         scn;
        int         cyc;
        logic       start;
        logic       stall;
        logic [9:0] exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst, start, stall, start0, stall0;
    logic [2:0] counter_r, stage_num_r, counter0, stage0;
    logic       run_en, bank_sel, busy, done;
    logic       run0, bank0, busy0, done0;
    logic [1:0] state_dbg, state0;

    int checks = 0;
    int failures = 0;
    int cyc;
    int run_cnt, busy_cnt, done_cnt, done_cyc;
    int run0_cnt, first_run0, last_run0, done0_cnt, done0_cyc;
    vec_t tab[$];

    always #5 clk = ~clk;

    fft_stage_sequencer u_dut (
        .clk(clk), .rst(rst), .start(start), .stall(stall),
        .counter_r(counter_r), .stage_num_r(stage_num_r), .run_en(run_en),
        .bank_sel(bank_sel), .busy(busy), .done(done), .state_dbg(state_dbg)
    );

    fft_stage_sequencer #(.PIPE_LAT(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .stall(stall0),
        .counter_r(counter0), .stage_num_r(stage0), .run_en(run0),
        .bank_sel(bank0), .busy(busy0), .done(done0), .state_dbg(state0)
    );

    function automatic logic [9:0] pk(input logic r, input logic [2:0] c, input logic [2:0] s,
                                      input logic b, input logic bu, input logic d);
        return {r, c, s, b, bu, d};
    endfunction

    function automatic vec_t mk(input int scn, input int cy, input logic st, input logic sl,
                                input logic r, input logic [2:0] c, input logic [2:0] s,
                                input logic b, input logic bu, input logic d);
        vec_t v;
        v.scn = scn; v.cyc = cy; v.start = st; v.stall = sl;
        v.exp = pk(r, c, s, b, bu, d);
        return v;
    endfunction

    function automatic logic [9:0] act_main();
        return {run_en, counter_r, stage_num_r, bank_sel, busy, done};
    endfunction

    function automatic logic [9:0] act_zero();
        return {run0, counter0, stage0, bank0, busy0, done0};
    endfunction

    task automatic check_vec(input string name, input logic [9:0] act, input logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got {run,cnt,stg,bank,busy,done}=%b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance to the next negedge; outputs are then stable for cycle `cyc`.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (run_en) run_cnt++;
        if (busy) busy_cnt++;
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (run0) begin
            if (first_run0 < 0) first_run0 = cyc;
            last_run0 = cyc;
            run0_cnt++;
        end
        if (done0) begin done0_cnt++; done0_cyc = cyc; end
    endtask

    task automatic clear_tally();
        run_cnt = 0; busy_cnt = 0; done_cnt = 0; done_cyc = -1;
        run0_cnt = 0; first_run0 = -1; last_run0 = -1; done0_cnt = 0; done0_cyc = -1;
    endtask

    task automatic begin_transform();
        int n;
        n = 0;
        while ((busy || done) && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) begin
            checks++;
            failures++;
            $display("FAIL idle_wait busy=%b done=%b after %0d cycles, expected idle", busy, done, n);
        end
        start = 1'b1;
        clear_tally();
        cyc = -1;
        step();
        start = 1'b0;
    endtask

    task automatic scen_end(input int s);
        check_int($sformatf("s%0d_run_cycles", s), run_cnt, 40);
        check_int($sformatf("s%0d_busy_cycles", s), busy_cnt, (s == 1) ? 50 : 53);
        check_int($sformatf("s%0d_done_count", s), done_cnt, 1);
        check_int($sformatf("s%0d_done_cycle", s), done_cyc, (s == 1) ? 51 : 54);
    endtask

    initial begin
        int cur;
        // Nominal run: stage k RUN 1+10k..8+10k, DRAIN 9+10k..10+10k, done at 51.
        tab.push_back(mk(1,  0, 0, 0, 0, 0, 0, 0, 0, 0));
        tab.push_back(mk(1,  1, 0, 0, 1, 0, 0, 0, 1, 0));
        tab.push_back(mk(1,  8, 0, 0, 1, 7, 0, 0, 1, 0));
        tab.push_back(mk(1,  9, 0, 0, 0, 7, 0, 0, 1, 0));
        tab.push_back(mk(1, 10, 0, 0, 0, 7, 0, 0, 1, 0));
        tab.push_back(mk(1, 11, 0, 0, 1, 0, 1, 1, 1, 0));
        tab.push_back(mk(1, 15, 1, 0, 1, 4, 1, 1, 1, 0));
        tab.push_back(mk(1, 20, 0, 0, 0, 7, 1, 1, 1, 0));
        tab.push_back(mk(1, 21, 0, 0, 1, 0, 2, 0, 1, 0));
        tab.push_back(mk(1, 30, 0, 0, 0, 7, 2, 0, 1, 0));
        tab.push_back(mk(1, 31, 0, 0, 1, 0, 3, 1, 1, 0));
        tab.push_back(mk(1, 38, 0, 0, 1, 7, 3, 1, 1, 0));
        tab.push_back(mk(1, 40, 0, 0, 0, 7, 3, 1, 1, 0));
        tab.push_back(mk(1, 41, 0, 0, 1, 0, 4, 0, 1, 0));
        tab.push_back(mk(1, 48, 0, 0, 1, 7, 4, 0, 1, 0));
        tab.push_back(mk(1, 50, 0, 0, 0, 7, 4, 0, 1, 0));
        tab.push_back(mk(1, 51, 0, 0, 0, 0, 0, 0, 0, 1));
        tab.push_back(mk(1, 52, 0, 0, 0, 0, 0, 0, 0, 0));
        // Three stall cycles at stage 2 counter 5: everything after shifts by 3.
        tab.push_back(mk(2, 25, 0, 0, 1, 4, 2, 0, 1, 0));
        tab.push_back(mk(2, 26, 0, 1, 1, 5, 2, 0, 1, 0));
        tab.push_back(mk(2, 27, 0, 1, 0, 5, 2, 0, 1, 0));
        tab.push_back(mk(2, 28, 0, 1, 0, 5, 2, 0, 1, 0));
        tab.push_back(mk(2, 29, 0, 0, 0, 5, 2, 0, 1, 0));
        tab.push_back(mk(2, 30, 0, 0, 1, 6, 2, 0, 1, 0));
        tab.push_back(mk(2, 31, 0, 0, 1, 7, 2, 0, 1, 0));
        tab.push_back(mk(2, 33, 0, 0, 0, 7, 2, 0, 1, 0));
        tab.push_back(mk(2, 34, 0, 0, 1, 0, 3, 1, 1, 0));
        tab.push_back(mk(2, 53, 0, 0, 0, 7, 4, 0, 1, 0));
        tab.push_back(mk(2, 54, 0, 0, 0, 0, 0, 0, 0, 1));
        tab.push_back(mk(2, 55, 0, 0, 0, 0, 0, 0, 0, 0));

        rst = 1'b1; start = 1'b0; stall = 1'b0; start0 = 1'b0; stall0 = 1'b0;
        cyc = 0;
        clear_tally();
        repeat (3) step();
        check_vec("reset_outputs", act_main(), 10'b0);
        check_int("reset_state", int'(state_dbg), 0);
        check_vec("reset_outputs_p0", act_zero(), 10'b0);
        rst = 1'b0;
        step();
        check_vec("idle_after_reset", act_main(), 10'b0);

        cur = 0;
        for (int i = 0; i < tab.size(); i++) begin
            if (tab[i].scn != cur) begin
                if (cur != 0) scen_end(cur);
                cur = tab[i].scn;
                begin_transform();
            end
            while (cyc < tab[i].cyc) step();
            check_vec($sformatf("s%0d_c%0d", tab[i].scn, tab[i].cyc), act_main(), tab[i].exp);
            start = tab[i].start;
            stall = tab[i].stall;
        end
        scen_end(cur);

        // Start mid-RUN and during DONE is ignored; start in the following cycle is taken.
        begin_transform();
        while (cyc < 15) step();
        start = 1'b1;
        step();
        start = 1'b0;
        check_vec("s3_midrun_start", act_main(), pk(1, 5, 1, 1, 1, 0));
        while (cyc < 51) step();
        check_vec("s3_done", act_main(), pk(0, 0, 0, 0, 0, 1));
        start = 1'b1;
        step();
        check_vec("s3_after_done_start", act_main(), 10'b0);
        check_int("s3_state_idle", int'(state_dbg), 0);
        step();
        start = 1'b0;
        check_vec("s3_still_idle", act_main(), 10'b0);
        check_int("s3_done_count", done_cnt, 1);
        cyc = 0;
        step();
        check_vec("s3_restart_c1", act_main(), pk(1, 0, 0, 0, 1, 0));

        // Reset mid-transform, asserted together with start and stall.
        while (cyc < 35) step();
        check_vec("s4_pre_reset", act_main(), pk(1, 4, 3, 1, 1, 0));
        rst = 1'b1; start = 1'b1; stall = 1'b1;
        step();
        rst = 1'b0; start = 1'b0; stall = 1'b0;
        check_vec("s4_reset_outputs", act_main(), 10'b0);
        check_int("s4_reset_state", int'(state_dbg), 0);
        step();
        check_vec("s4_idle_c1", act_main(), 10'b0);
        step();
        check_vec("s4_idle_c2", act_main(), 10'b0);
        begin_transform();
        step();
        check_vec("s4_restart_c1", act_main(), pk(1, 0, 0, 0, 1, 0));
        step();
        check_vec("s4_restart_c2", act_main(), pk(1, 1, 0, 0, 1, 0));

        // PIPE_LAT=0 build: back-to-back stages, done at 41.
        start0 = 1'b1;
        clear_tally();
        cyc = -1;
        step();
        start0 = 1'b0;
        while (cyc < 8) step();
        check_vec("p0_c8", act_zero(), pk(1, 7, 0, 0, 1, 0));
        step();
        check_vec("p0_c9", act_zero(), pk(1, 0, 1, 1, 1, 0));
        while (cyc < 40) step();
        check_vec("p0_c40", act_zero(), pk(1, 7, 4, 0, 1, 0));
        step();
        check_vec("p0_c41", act_zero(), pk(0, 0, 0, 0, 0, 1));
        step();
        check_vec("p0_c42", act_zero(), 10'b0);
        step();
        check_int("p0_run_cycles", run0_cnt, 40);
        check_int("p0_first_run", first_run0, 1);
        check_int("p0_last_run", last_run0, 40);
        check_int("p0_done_cycle", done0_cyc, 41);
        check_int("p0_done_count", done0_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
